// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU: opcodes, FSM state encoding and flag bit positions.
package alu_pkg;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_XOR = 4'd2;
   localparam logic [3:0] OP_AND = 4'd3;
   localparam logic [3:0] OP_OR  = 4'd4;
   localparam logic [3:0] OP_NOR = 4'd5;
   localparam logic [3:0] OP_SLL = 4'd6;
   localparam logic [3:0] OP_SRL = 4'd7;
   localparam logic [3:0] OP_SRA = 4'd8;
   localparam logic [3:0] OP_MUL = 4'd9;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_MUL  = 1'b1
   } state_t;

   localparam int unsigned FLAG_C = 0;
   localparam int unsigned FLAG_Z = 1;
   localparam int unsigned FLAG_N = 2;
   localparam int unsigned FLAG_O = 3;

endpackage

// File: rtl/alu_pipe_if.sv
// Issue and result handshake bundle between operand logic, the ALU and writeback.
interface alu_pipe_if #(
   parameter int unsigned WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic [3:0]       opcode;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             cout;
   logic             z;
   logic             n;
   logic             o;

   modport master (
      output in_valid, a, b, cin, opcode, out_ready,
      input  in_ready, out_valid, result, cout, z, n, o
   );

   modport slave (
      input  in_valid, a, b, cin, opcode, out_ready,
      output in_ready, out_valid, result, cout, z, n, o
   );
endinterface

// File: rtl/alu_core.sv
// Combinational datapath for all single-cycle ALU operations (result, carry, signed overflow).
module alu_core
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic [3:0]       opcode,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             o
);
   localparam int unsigned SHW = $clog2(WIDTH);

   logic [SHW-1:0] amt;
   logic [WIDTH:0] sum;

   assign amt = b[SHW-1:0];

   always_comb begin
      result = '0;
      cout   = 1'b0;
      o      = 1'b0;
      sum    = '0;
      case (opcode)
         OP_ADD: begin
            sum    = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
            result = sum[WIDTH-1:0];
            cout   = sum[WIDTH];
            o      = (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            // Carry out of a + ~b + 1 is the "no borrow" (a >= b unsigned) flag.
            sum    = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
            result = sum[WIDTH-1:0];
            cout   = sum[WIDTH];
            o      = (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
         end
         OP_XOR: result = a ^ b;
         OP_AND: result = a & b;
         OP_OR:  result = a | b;
         OP_NOR: result = ~(a | b);
         OP_SLL: result = a << amt;
         OP_SRL: result = a >> amt;
         OP_SRA: result = $unsigned($signed(a) >>> amt);
         default: ;
      endcase
   end

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshake and flag register.
// Define ALU_PIPE_MUL_EN to build the iterative shift-add multiplier behind opcode 9.
module alu_pipe
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input logic       clk,
   input logic       rst,
   alu_pipe_if.slave bus
);
   localparam int unsigned CW = $clog2(WIDTH + 1);

   logic [WIDTH-1:0] core_result;
   logic             core_cout;
   logic             core_o;

   state_t           state_q;
   logic             accept;
   logic             is_mul;
   logic             slot_free;
   logic             mul_done;
   logic [WIDTH-1:0] mul_res;
   logic             mul_ovf;

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [3:0]       flags_q, flags_d;
   logic             load;

   assign slot_free    = !out_valid_q || bus.out_ready;
   assign bus.in_ready = (state_q == ST_IDLE) && slot_free;
   assign accept       = bus.in_valid && bus.in_ready;

   alu_core #(
      .WIDTH(WIDTH)
   ) u_core (
      .a      (bus.a),
      .b      (bus.b),
      .cin    (bus.cin),
      .opcode (bus.opcode),
      .result (core_result),
      .cout   (core_cout),
      .o      (core_o)
   );

`ifdef ALU_PIPE_MUL_EN
   state_t             state_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [CW-1:0]      cnt_q, cnt_d;

   assign is_mul = (bus.opcode == OP_MUL);

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (accept && is_mul) begin
               state_d  = ST_MUL;
               acc_d    = '0;
               mcand_d  = {{WIDTH{1'b0}}, bus.a};
               mplier_d = bus.b;
               cnt_d    = '0;
            end
         end
         ST_MUL: begin
            if (cnt_q != CW'(WIDTH)) begin
               if (mplier_q[0]) acc_d = acc_q + mcand_q;
               mcand_d  = mcand_q << 1;
               mplier_d = mplier_q >> 1;
               cnt_d    = cnt_q + CW'(1);
            end else if (slot_free) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
      end
   end

   // All steps done; completion waits here while the output slot is still occupied.
   assign mul_done = (state_q == ST_MUL) && (cnt_q == CW'(WIDTH)) && slot_free;
   assign mul_res  = acc_q[WIDTH-1:0];
   assign mul_ovf  = |acc_q[2*WIDTH-1:WIDTH];
`else
   assign state_q  = ST_IDLE;
   assign is_mul   = 1'b0;
   assign mul_done = 1'b0;
   assign mul_res  = '0;
   assign mul_ovf  = 1'b0;
`endif

   always_comb begin
      out_valid_d = out_valid_q;
      result_d    = result_q;
      flags_d     = flags_q;
      load        = 1'b0;
      if (bus.out_ready) out_valid_d = 1'b0;
      if (accept && !is_mul) begin
         load            = 1'b1;
         result_d        = core_result;
         flags_d[FLAG_C] = core_cout;
         flags_d[FLAG_O] = core_o;
      end else if (mul_done) begin
         load            = 1'b1;
         result_d        = mul_res;
         flags_d[FLAG_C] = 1'b0;
         flags_d[FLAG_O] = mul_ovf;
      end
      if (load) begin
         out_valid_d     = 1'b1;
         flags_d[FLAG_Z] = (result_d == '0);
         flags_d[FLAG_N] = result_d[WIDTH-1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         result_q    <= '0;
         flags_q     <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         flags_q     <= flags_d;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.result    = result_q;
   assign bus.cout      = flags_q[FLAG_C];
   assign bus.z         = flags_q[FLAG_Z];
   assign bus.n         = flags_q[FLAG_N];
   assign bus.o         = flags_q[FLAG_O];

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe (WIDTH=32): directed spec cases, abort-on-reset and random traffic
// against an arithmetic reference model; honours ALU_PIPE_MUL_EN.
module tb_alu_pipe;
   localparam int unsigned WIDTH = 32;

   typedef struct packed {
      logic [31:0] result;
      logic        cout;
      logic        z;
      logic        n;
      logic        o;
   } resp_t;

   typedef struct {
      resp_t r;
      int    lat;  // expected cycle-count difference at first presentation, 0 = unchecked
      int    acc;
   } exp_t;

   logic clk;
   logic rst;
   int   tests = 0;
   int   fails = 0;
   int   cyc   = 0;
   bit   bp_en = 0;
   exp_t q[$];

   alu_pipe_if #(.WIDTH(WIDTH)) bus ();

   alu_pipe #(
      .WIDTH(WIDTH)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Random back-pressure, applied just after each rising edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (bp_en) bus.out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

`ifdef ALU_PIPE_MUL_EN
   localparam bit MUL_ON = 1'b1;
`else
   localparam bit MUL_ON = 1'b0;
`endif

   function automatic resp_t mk(logic [31:0] res, logic c, logic o);
      resp_t r;
      r.result = res;
      r.cout   = c;
      r.o      = o;
      r.z      = (res == 32'h0);
      r.n      = res[31];
      return r;
   endfunction

   function automatic logic ovf32(longint s);
      return (s > 64'sd2147483647) || (s < -64'sd2147483648);
   endfunction

   function automatic resp_t model(logic [3:0] op, logic [31:0] a, logic [31:0] b, logic cin);
      longint unsigned ua = {32'h0, a};
      longint unsigned ub = {32'h0, b};
      longint          sa = longint'($signed(a));
      longint          sb = longint'($signed(b));
      logic [63:0]     p;
      int              amt = int'(b % 32);
      case (op)
         4'd0: begin
            p = ua + ub + {63'h0, cin};
            return mk(p[31:0], p[32], ovf32(sa + sb + longint'(cin)));
         end
         4'd1: begin
            p = ua - ub;
            return mk(p[31:0], ua >= ub, ovf32(sa - sb));
         end
         4'd2: return mk(a ^ b, 1'b0, 1'b0);
         4'd3: return mk(a & b, 1'b0, 1'b0);
         4'd4: return mk(a | b, 1'b0, 1'b0);
         4'd5: return mk(~(a | b), 1'b0, 1'b0);
         4'd6: return mk(a << amt, 1'b0, 1'b0);
         4'd7: return mk(a >> amt, 1'b0, 1'b0);
         4'd8: return mk($unsigned($signed(a) >>> amt), 1'b0, 1'b0);
         4'd9: begin
            if (MUL_ON) begin
               p = ua * ub;
               return mk(p[31:0], 1'b0, p[63:32] != 32'h0);
            end
            return mk(32'h0, 1'b0, 1'b0);
         end
         default: return mk(32'h0, 1'b0, 1'b0);
      endcase
   endfunction

   // Called at a falling edge; returns at the falling edge after the accepting rising edge.
   task automatic issue_exp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic cin, input resp_t e, input int lat);
      int   n = 0;
      exp_t x;
      bus.opcode   = op;
      bus.a        = a;
      bus.b        = b;
      bus.cin      = cin;
      bus.in_valid = 1'b1;
      while (!bus.in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!bus.in_ready) begin
         tests++;
         fails++;
         $display("FAIL issue_timeout: in_ready still %b after %0d cycles, expected 1", bus.in_ready, n);
         bus.in_valid = 1'b0;
         return;
      end
      x.r   = e;
      x.lat = lat;
      x.acc = cyc;
      q.push_back(x);
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic cin);
      int lat;
      if (MUL_ON && op == 4'd9) lat = bp_en ? 0 : WIDTH + 2;
      else lat = 1;
      issue_exp(op, a, b, cin, model(op, a, b, cin), lat);
   endtask

   // Monitor: pops and compares on every transfer, checks hold stability and first-presentation latency.
   bit    prev_valid = 0;
   bit    prev_xfer  = 0;
   resp_t prev_pk;
   resp_t cur;
   exp_t  popped;

   always @(negedge clk) begin
      if (rst) begin
         prev_valid = 0;
         prev_xfer  = 0;
      end else begin
         cur = {bus.result, bus.cout, bus.z, bus.n, bus.o};
         if (bus.out_valid) begin
            if (prev_valid && !prev_xfer) check("hold_stable", 64'(cur), 64'(prev_pk));
            else if (q.size() != 0 && q[0].lat != 0)
               check("latency", 64'(cyc - q[0].acc), 64'(q[0].lat));
            if (bus.out_ready) begin
               if (q.size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL unexpected_output: got %h, expected no result", cur);
               end else begin
                  popped = q.pop_front();
                  check("result_flags", 64'(cur), 64'(popped.r));
               end
            end
         end
         prev_valid = bus.out_valid;
         prev_xfer  = bus.out_valid && bus.out_ready;
         prev_pk    = cur;
      end
   end

   task automatic check_reset_state(input string name);
      check(name, {26'h0, bus.out_valid, bus.in_ready, bus.result, bus.cout, bus.z, bus.n, bus.o},
            {26'h0, 1'b0, 1'b1, 32'h0, 4'b0000});
   endtask

   logic [3:0]  rop;
   logic [31:0] ra, rb;
   int          seen;

   function automatic logic [31:0] pick_operand();
      int unsigned sel = $urandom_range(0, 7);
      case (sel)
         0: return 32'h0000_0000;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.cin       = 1'b0;
      bus.opcode    = '0;
      bus.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_reset_state("reset_state");

      issue_exp(4'd0, 32'h7FFF_FFFF, 32'h1, 1'b0, mk(32'h8000_0000, 1'b0, 1'b1), 1);
      issue_exp(4'd1, 32'h5, 32'h5, 1'b1, mk(32'h0, 1'b1, 1'b0), 1);
      issue_exp(4'd1, 32'h8000_0000, 32'h1, 1'b0, mk(32'h7FFF_FFFF, 1'b1, 1'b1), 1);
      issue_exp(4'd8, 32'hF000_0000, 32'd4, 1'b0, mk(32'hFF00_0000, 1'b0, 1'b0), 1);
      issue_exp(4'd7, 32'hF000_0000, 32'd4, 1'b0, mk(32'h0F00_0000, 1'b0, 1'b0), 1);
      issue_exp(4'd6, 32'h1, 32'd33, 1'b0, mk(32'h2, 1'b0, 1'b0), 1);
      issue_exp(4'd12, 32'h1234, 32'h5678, 1'b1, mk(32'h0, 1'b0, 1'b0), 1);

      // Back-to-back: in_valid stays high across the three accepts.
      issue_exp(4'd0, 32'd1, 32'd1, 1'b0, mk(32'd2, 1'b0, 1'b0), 1);
      issue_exp(4'd0, 32'd2, 32'd2, 1'b0, mk(32'd4, 1'b0, 1'b0), 1);
      issue_exp(4'd0, 32'd3, 32'd3, 1'b0, mk(32'd6, 1'b0, 1'b0), 1);
      @(negedge clk);

      // Stall the output slot for three cycles.
      @(posedge clk);
      #1 bus.out_ready = 1'b0;
      @(negedge clk);
      issue_exp(4'd0, 32'd1, 32'd1, 1'b0, mk(32'd2, 1'b0, 1'b0), 1);
      bus.in_valid = 1'b1;
      bus.opcode   = 4'd2;
      for (int i = 0; i < 3; i++) begin
         check("stall_hold", {29'h0, bus.in_ready, bus.out_valid, bus.result},
               {29'h0, 1'b0, 1'b1, 32'd2});
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      @(posedge clk);
      #1 bus.out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);

      issue_exp(4'd9, 32'h0001_0000, 32'h0001_0000, 1'b0,
                mk(32'h0, 1'b0, MUL_ON), MUL_ON ? WIDTH + 2 : 1);
      repeat (40) @(negedge clk);

      if (MUL_ON) begin
         // Abort a multiply with reset at accept+10; nothing may come out.
         bus.opcode   = 4'd9;
         bus.a        = 32'h0001_0000;
         bus.b        = 32'h0001_0000;
         bus.in_valid = 1'b1;
         check("mul_ready", 64'(bus.in_ready), 64'(1));
         @(negedge clk);
         bus.in_valid = 1'b0;
         repeat (9) @(negedge clk);
         rst = 1'b1;
         @(negedge clk);
         rst = 1'b0;
         check_reset_state("abort_reset_state");
         seen = 0;
         repeat (40) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
         end
         check("abort_no_output", 64'(seen), 64'(0));
      end

      bp_en = 1'b1;
      for (int i = 0; i < 300; i++) begin
         rop = 4'($urandom_range(0, 19));
         if (rop > 4'd15 || i % 16 == 0) rop = 4'd9;
         ra = pick_operand();
         rb = pick_operand();
         issue(rop, ra, rb, 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 3) == 0) @(negedge clk);
      end
      bp_en = 1'b0;
      @(posedge clk);
      #2 bus.out_ready = 1'b1;
      @(negedge clk);
      seen = 0;
      while (q.size() != 0 && seen < 500) begin
         @(negedge clk);
         seen++;
      end
      check("drain_empty", 64'(q.size()), 64'(0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
